// File: rtl/dmem_request_unit_pkg.sv
// Shared types for the data-memory request unit: FSM states, RV32I load/store funct3 codes
// and the alignment helper used when DMEM_ALIGN_CHECK_EN is defined.
package dmem_request_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } dmem_state_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_t;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // Halfword codes coincide for loads and stores, as do word codes, so one check serves both.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic result;
    result = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: result = offset[0];
      F3_LW:         result = |offset;
      default:       result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dmem_request_unit_store_align.sv
// Combinational store lane steering: builds the byte write mask and shifts store data
// into the lanes selected by the low address bits.
module store_align
  import dmem_request_unit_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  output logic [3:0]  wmask,
  output logic [31:0] wdata
);

  logic [3:0] base_mask;

  always_comb begin
    base_mask = 4'b0000;
    if (is_store) begin
      case (funct3)
        F3_SB:   base_mask = MASK_BYTE;
        F3_SH:   base_mask = MASK_HALF;
        F3_SW:   base_mask = MASK_WORD;
        default: base_mask = 4'b0000;
      endcase
    end
  end

  // Shifting a 4-bit mask drops lanes past byte 3, which is the intended truncation.
  always_comb begin
    wmask = base_mask << offset;
    wdata = 32'h0000_0000;
    if (base_mask != 4'b0000) begin
      wdata = store_data << {offset, 3'b000};
    end
  end

endmodule

// File: rtl/dmem_request_unit.sv
// MEM-stage data memory requester: issues one word-aligned load/store per instruction and
// stalls until the memory responds. Define DMEM_ALIGN_CHECK_EN to reject misaligned accesses.
module dmem_request_unit
  import dmem_request_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] store_data,
  input  logic        pipe_stall,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic        misalign_err
);

  dmem_state_t state;
  dmem_state_t next_state;

  logic        access;
  logic        misaligned;
  logic        start;
  logic [31:0] new_addr;
  logic [3:0]  new_wmask;
  logic [31:0] new_wdata;

  logic [31:0] req_addr_q;
  logic        req_read_q;
  logic        req_write_q;
  logic [3:0]  req_wmask_q;
  logic [31:0] req_wdata_q;
  logic [31:0] hold_rdata_q;

  // Qualifying with rst keeps the combinational IDLE request quiet while reset is held.
  assign access   = rst & ex_valid & (mem_read | mem_write);
  assign new_addr = {mem_addr[31:2], 2'b00};

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned   = is_misaligned(funct3, mem_addr[1:0]);
  assign misalign_err = (state == ST_IDLE) & access & misaligned;
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign start = (state == ST_IDLE) & access & ~misaligned;

  store_align u_store_align (
    .is_store   (mem_write),
    .funct3     (funct3),
    .offset     (mem_addr[1:0]),
    .store_data (store_data),
    .wmask      (new_wmask),
    .wdata      (new_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The request is captured on the IDLE cycle so it stays stable even if EX/MEM inputs move.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr_q  <= 32'h0000_0000;
      req_read_q  <= 1'b0;
      req_write_q <= 1'b0;
      req_wmask_q <= 4'b0000;
      req_wdata_q <= 32'h0000_0000;
    end else if (start) begin
      req_addr_q  <= new_addr;
      req_read_q  <= mem_read;
      req_write_q <= mem_write;
      req_wmask_q <= new_wmask;
      req_wdata_q <= new_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_rdata_q <= 32'h0000_0000;
    end else if ((state == ST_REQ) && dmem_resp && pipe_stall) begin
      hold_rdata_q <= dmem_rdata;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_REQ;
      end
      ST_REQ: begin
        if (dmem_resp) next_state = pipe_stall ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (!pipe_stall) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    dmem_address = 32'h0000_0000;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_wmask   = 4'b0000;
    dmem_wdata   = 32'h0000_0000;
    mem_stall    = 1'b0;
    mem_rdata    = 32'h0000_0000;
    case (state)
      ST_IDLE: begin
        if (start) begin
          dmem_address = new_addr;
          dmem_read    = mem_read;
          dmem_write   = mem_write;
          dmem_wmask   = new_wmask;
          dmem_wdata   = new_wdata;
          mem_stall    = 1'b1;
        end
      end
      ST_REQ: begin
        dmem_address = req_addr_q;
        dmem_read    = req_read_q;
        dmem_write   = req_write_q;
        dmem_wmask   = req_wmask_q;
        dmem_wdata   = req_wdata_q;
        mem_stall    = ~(dmem_resp & ~pipe_stall);
        mem_rdata    = dmem_rdata;
      end
      ST_HOLD: begin
        mem_rdata = hold_rdata_q;
      end
      default: begin
        mem_rdata = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_request_unit.sv
// Scoreboard bench for dmem_request_unit: stimulus queues expected handshakes, a monitor
// compares them at each completion; state-specific checks are made inline.
module tb_dmem_request_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic        pipe_stall;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        mem_stall;
  logic [31:0] mem_rdata;
  logic        misalign_err;

  dmem_request_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .mem_addr     (mem_addr),
    .store_data   (store_data),
    .pipe_stall   (pipe_stall),
    .dmem_resp    (dmem_resp),
    .dmem_rdata   (dmem_rdata),
    .dmem_address (dmem_address),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .mem_stall    (mem_stall),
    .mem_rdata    (mem_rdata),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [31:0] rdata;
    logic        stall_end;
    int          req_cycles;
    int          stall_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check_output({name, ".read"},  32'(dmem_read),  32'd0);
    check_output({name, ".write"}, 32'(dmem_write), 32'd0);
    check_output({name, ".stall"}, 32'(mem_stall),  32'd0);
    check_output({name, ".rdata"}, mem_rdata,       32'd0);
  endtask

  // Monitor: tracks each request from first cycle to dmem_resp and scores it on completion.
  initial begin : monitor
    int          cyc;
    int          stl;
    logic        unstable;
    logic [31:0] s_addr;
    logic        s_rd;
    logic        s_wr;
    logic [3:0]  s_mask;
    logic [31:0] s_wdata;
    exp_t        e;
    cyc = 0; stl = 0; unstable = 1'b0;
    s_addr = '0; s_rd = 1'b0; s_wr = 1'b0; s_mask = '0; s_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst || !(dmem_read || dmem_write)) begin
        cyc = 0; stl = 0; unstable = 1'b0;
      end else begin
        if (cyc == 0) begin
          s_addr = dmem_address; s_rd = dmem_read; s_wr = dmem_write;
          s_mask = dmem_wmask; s_wdata = dmem_wdata;
        end else if (s_addr !== dmem_address || s_rd !== dmem_read || s_wr !== dmem_write ||
                     s_mask !== dmem_wmask || s_wdata !== dmem_wdata) begin
          unstable = 1'b1;
        end
        cyc++;
        if (mem_stall) stl++;
        if (dmem_resp) begin
          if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected_handshake: got addr 0x%08h, expected none", dmem_address);
          end else begin
            e = exp_q.pop_front();
            check_output({e.name, ".addr"},   dmem_address,      e.addr);
            check_output({e.name, ".rd"},     32'(dmem_read),    32'(e.rd));
            check_output({e.name, ".wr"},     32'(dmem_write),   32'(e.wr));
            check_output({e.name, ".mask"},   32'(dmem_wmask),   32'(e.mask));
            if (e.chk_wdata) check_output({e.name, ".wdata"}, dmem_wdata, e.wdata);
            check_output({e.name, ".rdata"},  mem_rdata,         e.rdata);
            check_output({e.name, ".stall_end"}, 32'(mem_stall), 32'(e.stall_end));
            check_output({e.name, ".req_cycles"}, 32'(cyc),      32'(e.req_cycles));
            check_output({e.name, ".stall_cycles"}, 32'(stl),    32'(e.stall_cycles));
            check_output({e.name, ".stable"}, 32'(unstable),     32'd0);
          end
          cyc = 0; stl = 0; unstable = 1'b0;
        end
      end
    end
  end

  task automatic apply_stimulus(
    input string       name,
    input logic        is_load,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] data,
    input int          resp_delay,
    input logic [31:0] rdata,
    input int          hold_cycles,
    input logic        drop_ex,
    input logic [31:0] exp_addr,
    input logic [3:0]  exp_mask,
    input logic [31:0] exp_wdata,
    input logic        chk_wdata
  );
    exp_t e;
    e.name = name; e.addr = exp_addr; e.rd = is_load; e.wr = !is_load;
    e.mask = exp_mask; e.wdata = exp_wdata; e.chk_wdata = chk_wdata; e.rdata = rdata;
    e.stall_end = (hold_cycles > 0);
    e.req_cycles = resp_delay + 1;
    e.stall_cycles = resp_delay + ((hold_cycles > 0) ? 1 : 0);
    exp_q.push_back(e);

    ex_valid = 1'b1; mem_read = is_load; mem_write = !is_load; funct3 = f3;
    mem_addr = addr; store_data = data; pipe_stall = 1'b0; dmem_resp = 1'b0;
    for (int i = 0; i < resp_delay; i++) begin
      tick();
      if (drop_ex) begin
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b111;
        mem_addr = 32'hFFFF_FFFF; store_data = 32'h5A5A_5A5A;
      end
    end
    dmem_resp = 1'b1; dmem_rdata = rdata; pipe_stall = (hold_cycles > 0);
    tick();
    dmem_resp = 1'b0; dmem_rdata = 32'hBAD0_BAD0;
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    for (int i = 0; i < hold_cycles; i++) begin
      pipe_stall = (i < hold_cycles - 1);
      @(negedge clk);
      check_output({name, ".hold_rdata"}, mem_rdata,        rdata);
      check_output({name, ".hold_read"},  32'(dmem_read),   32'd0);
      check_output({name, ".hold_write"}, 32'(dmem_write),  32'd0);
      check_output({name, ".hold_stall"}, 32'(mem_stall),   32'd0);
      tick();
    end
    pipe_stall = 1'b0;
    @(negedge clk);
    check_idle({name, ".after"});
    tick();
  endtask

  initial begin : stimulus
    int drain;
    rst = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    mem_addr = 32'h0; store_data = 32'h0; pipe_stall = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'h0;

    @(negedge clk);
    check_output("reset.address", dmem_address,       32'd0);
    check_output("reset.wmask",   32'(dmem_wmask),    32'd0);
    check_output("reset.wdata",   dmem_wdata,         32'd0);
    check_output("reset.misalign", 32'(misalign_err), 32'd0);
    check_idle("reset");

    // Stray response in the first cycle after reset release must be ignored.
    tick();
    rst = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_idle("stray_resp0");
    tick();
    dmem_resp = 1'b0;
    @(negedge clk);
    check_idle("stray_resp1");
    tick();

    apply_stimulus("sb_1003", 1'b0, 3'b000, 32'h0000_1003, 32'h0000_00AB, 2, 32'h0, 0, 1'b0,
                   32'h0000_1000, 4'b1000, 32'hAB00_0000, 1'b1);
    apply_stimulus("sh_2002", 1'b0, 3'b001, 32'h0000_2002, 32'h0000_1234, 1, 32'h0, 0, 1'b0,
                   32'h0000_2000, 4'b1100, 32'h1234_0000, 1'b1);
    apply_stimulus("lw_3000", 1'b1, 3'b010, 32'h0000_3000, 32'h0, 1, 32'hDEAD_BEEF, 0, 1'b0,
                   32'h0000_3000, 4'b0000, 32'h0, 1'b1);
    apply_stimulus("lw_hold", 1'b1, 3'b010, 32'h0000_3004, 32'h0, 1, 32'hDEAD_BEEF, 3, 1'b0,
                   32'h0000_3004, 4'b0000, 32'h0, 1'b1);
    apply_stimulus("sw_drop", 1'b0, 3'b010, 32'h0000_5008, 32'hCAFE_F00D, 3, 32'h0, 0, 1'b1,
                   32'h0000_5008, 4'b1111, 32'hCAFE_F00D, 1'b1);
    apply_stimulus("sb_1001", 1'b0, 3'b000, 32'h0000_1001, 32'h1234_5678, 1, 32'h0, 0, 1'b0,
                   32'h0000_1000, 4'b0010, 32'h3456_7800, 1'b1);
    apply_stimulus("st_f3_011", 1'b0, 3'b011, 32'h0000_6000, 32'h0000_0099, 2, 32'h0, 0, 1'b0,
                   32'h0000_6000, 4'b0000, 32'h0, 1'b0);
    apply_stimulus("lbu_7003", 1'b1, 3'b100, 32'h0000_7003, 32'h0, 1, 32'h1122_3344, 0, 1'b0,
                   32'h0000_7000, 4'b0000, 32'h0, 1'b1);

`ifdef DMEM_ALIGN_CHECK_EN
    ex_valid = 1'b1; mem_write = 1'b1; funct3 = 3'b010; mem_addr = 32'h0000_4001;
    store_data = 32'h1122_3344;
    @(negedge clk);
    check_output("sw_4001.misalign", 32'(misalign_err), 32'd1);
    check_output("sw_4001.write",    32'(dmem_write),   32'd0);
    check_output("sw_4001.stall",    32'(mem_stall),    32'd0);
    tick();
    ex_valid = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check_output("sw_4001.misalign_end", 32'(misalign_err), 32'd0);
    check_idle("sw_4001.after");
    tick();
`else
    apply_stimulus("sw_4001", 1'b0, 3'b010, 32'h0000_4001, 32'h1122_3344, 1, 32'h0, 0, 1'b0,
                   32'h0000_4000, 4'b1110, 32'h0, 1'b0);
    apply_stimulus("sh_2003", 1'b0, 3'b001, 32'h0000_2003, 32'h0000_BEEF, 1, 32'h0, 0, 1'b0,
                   32'h0000_2000, 4'b1000, 32'hEF00_0000, 1'b1);
`endif

    // Reset asserted mid-request while EX/MEM still presents a load.
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; mem_addr = 32'h0000_8000;
    tick();
    @(negedge clk);
    check_output("rst_mid.in_req", 32'(dmem_read), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_output("rst_mid.address", dmem_address,    32'd0);
    check_output("rst_mid.wmask",   32'(dmem_wmask), 32'd0);
    check_output("rst_mid.wdata",   dmem_wdata,      32'd0);
    check_idle("rst_mid");
    tick();
    ex_valid = 1'b0; mem_read = 1'b0;
    tick();
    rst = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    check_idle("rst_mid.stray");
    tick();
    dmem_resp = 1'b0;
    @(negedge clk);
    check_idle("rst_mid.after");
    tick();

    drain = 0;
    while (exp_q.size() != 0 && drain < 20) begin
      tick();
      drain++;
    end
    check_output("scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_request_unit.md
DMEM_REQUEST_UNIT -- requirements
Module: dmem_request_unit

Interface
REQ-001 SHALL have no parameters; all widths fixed at 32-bit RV32I data and address.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 ex_valid  in  1  EX/MEM instruction valid.
REQ-005 mem_read / mem_write  in  1 each  load / store request from ctrl word; never both set.
REQ-006 funct3  in  3  access size: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-007 mem_addr  in  32  byte address (alu_out).
REQ-008 store_data  in  32  rs2 data.
REQ-009 pipe_stall  in  1  stall from other sources (imem etc.); MEM/WB does not advance while high.
REQ-010 dmem_resp  in  1  memory completion strobe; dmem_rdata  in  32  word read data, valid with dmem_resp.
REQ-011 dmem_address  out  32  word-aligned address; dmem_read / dmem_write  out  1 each; dmem_wmask  out  4; dmem_wdata  out  32.
REQ-012 mem_stall  out  1  this unit holds the pipeline.
REQ-013 mem_rdata  out  32  unshifted word to MEM/WB; writeback does byte select and extension.
REQ-014 misalign_err  out  1  one-cycle misaligned-access flag (only with DMEM_ALIGN_CHECK_EN).

Function
REQ-015 SHALL implement FSM IDLE, REQ, HOLD.
REQ-016 IDLE: ex_valid with mem_read|mem_write -> REQ in the same cycle, combinationally driving the request and mem_stall=1; otherwise stay IDLE, all request outputs 0.
REQ-017 REQ: request outputs held stable every cycle until dmem_resp; mem_stall=1.
REQ-018 REQ with dmem_resp and pipe_stall=0 -> IDLE; mem_stall=0 that cycle; mem_rdata=dmem_rdata combinationally.
REQ-019 REQ with dmem_resp and pipe_stall=1 -> HOLD; dmem_rdata latched into a register; request deasserted next cycle.
REQ-020 HOLD: mem_stall=0, no request; mem_rdata=latched word; stay until pipe_stall=0, then -> IDLE.
REQ-021 Fastest load or store: one cycle in REQ when dmem_resp arrives in the first REQ cycle; no request ever reissued for the same instruction.
REQ-022 dmem_address={mem_addr[31:2],2'b00}.
REQ-023 Store sb: wmask=4'b0001<<mem_addr[1:0]; wdata=store_data<<(8*mem_addr[1:0]).
REQ-024 Store sh: wmask=4'b0011<<mem_addr[1:0], truncated to 4 bits; wdata shifted as REQ-023.
REQ-025 Store sw: wmask=4'b1111; wdata=store_data.
REQ-026 Loads: wmask=4'b0000, wdata=0.
REQ-027 Undefined funct3 on store: wmask=0 and the write still handshakes. Makes no memory change.
REQ-028 ex_valid dropping while in REQ SHALL NOT abort the request; the handshake completes.

Reset
REQ-029 Asserting rst in any state SHALL force IDLE asynchronously. Outputs: dmem_read=0, dmem_write=0, wmask=0, wdata=0, address=0, mem_stall=0, mem_rdata=0, latched word=0, misalign_err=0.
REQ-030 A dmem_resp arriving in the first cycle after reset release in IDLE SHALL be ignored.

Configuration
REQ-031 With DMEM_ALIGN_CHECK_EN defined, a misaligned access (h/hu with addr[0]=1; w with addr[1:0]!=0) SHALL issue no request, stay IDLE, hold mem_stall=0, and pulse misalign_err for one cycle.
REQ-032 Without DMEM_ALIGN_CHECK_EN, misaligned accesses issue normally with truncated mask per REQ-024; misalign_err is tied 0.

Structure
REQ-033 State enum and funct3 load/store size constants SHALL live in the shared types package, reusing the existing load/store funct3 enums.
REQ-034 Store alignment (wmask/wdata generation) SHALL be a combinational sub-module store_align; the FSM stays in dmem_request_unit.

Verification
REQ-035 Store sb with addr=0x1003, data=0x000000AB, resp after 2 cycles -> address 0x1000, wmask 1000, wdata 0xAB000000, mem_stall high 2 cycles.
REQ-036 Store sh with addr=0x2002, data=0x1234 -> wmask 1100, wdata 0x12340000, single write.
REQ-037 Load lw with addr=0x3000, resp in first cycle with rdata=0xDEADBEEF, pipe_stall=0 -> mem_rdata 0xDEADBEEF, return to IDLE next cycle.
REQ-038 Load with resp while pipe_stall=1 for 3 cycles -> HOLD for 3 cycles, mem_rdata stable 0xDEADBEEF, dmem_read low after resp, no re-request.
REQ-039 rst asserted mid-REQ -> all outputs 0 immediately, IDLE, and a following stray dmem_resp ignored.
REQ-040 With DMEM_ALIGN_CHECK_EN, sw to 0x4001 -> no dmem_write, misalign_err one-cycle pulse; without the macro -> write with wmask 1110.
